cv_bus_master: RTL and testbench
================================

# cv_bus_master

Z80-style bus initiator for the Colecovision/Adam core. It converts single-transaction requests into T-state-accurate memory, I/O and M1-with-refresh bus cycles. Its outputs drive the same `mreq_n`/`iorq_n`/`rd_n`/`wr_n`/`rfsh_n`/address/data bus that the address decoder consumes. It serves as a loader/debug master that shares the bus in place of the CPU, and as a stimulus source for decoder and memory verification.

## Interface
Parameters:
- `RESET_ADDR`, default 16'h0000: value of `a_o` out of reset.

Ports:
- `clk_i` in 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n_i` in 1: asynchronous active-low reset.
- `clk_en_i` in 1: T-state tick; the FSM advances only on edges where this is 1.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: equals 1 exactly when the FSM is in IDLE.
- `req_type_i` in 2: 00 mem read, 01 mem write, 10 I/O read, 11 I/O write.
- `req_m1_i` in 1: opcode fetch with refresh; honoured only for type 00.
- `req_addr_i` in 16: cycle address.
- `req_data_i` in 8: write data.
- `rsp_valid_o` out 1: one-clock pulse when read data is ready.
- `rsp_data_o` out 8: captured read data; holds its value until the next capture.
- `a_o` out 16: address bus.
- `d_o` out 8: data out.
- `d_oe_o` out 1: data-out enable.
- `d_i` in 8: data-in bus.
- `mreq_n_o`, `iorq_n_o`, `rd_n_o`, `wr_n_o`, `rfsh_n_o`, `m1_n_o` out 1 each: bus strobes, active low.
- `wait_n_i` in 1: wait request, active low.
- `busy_o` out 1: equals `~req_ready_o`.

## Operation
- All outputs are registered.
- States: IDLE, T1, T2, TWA (automatic I/O wait), TW, T3, T4 (M1 only).
- A request is accepted on a tick in IDLE with `req_valid_i`=1. On acceptance the block latches the type, m1, address and data, and moves to T1.
- **T1:** `a_o` = addr.
  - Mem cycles: `mreq_n_o`=0.
  - Mem read: `rd_n_o`=0.
  - M1: `m1_n_o`=0.
  - Writes: `d_o` = data, `d_oe_o`=1 from T1 until the block returns to IDLE.
  - I/O cycles: no strobe asserted in T1.
- **T2:** mem strobes and `m1_n_o` held.
  - Mem write: `wr_n_o`=0.
  - I/O: `iorq_n_o`=0 plus `rd_n_o` or `wr_n_o`=0. I/O then always proceeds T2→TWA.
- **Wait sampling:** `wait_n_i` is sampled on the tick leaving T2 (mem) or TWA (I/O).
  - Sampled 0: go to TW, and stay in TW while `wait_n_i`=0 on each tick.
  - Sampled 1: go to T3.
- **Non-M1 cycles, T3:** strobes held. On the tick leaving T3, reads capture `d_i` into `rsp_data_o`. The block then returns to IDLE with all strobes high and `d_oe_o`=0.
- **M1 cycles:**
  - Data is captured on the tick leaving T2 or TW.
  - T3: `a_o` = {8'h00, r_cnt}, `rfsh_n_o`=0, `mreq_n_o`=0, `rd_n_o`=1, `m1_n_o`=1.
  - T4: `rfsh_n_o`=0, `mreq_n_o`=1.
  - On the tick leaving T4, r_cnt[6:0] increments modulo 128 and r_cnt[7] stays 0. The block then returns to IDLE.
- `req_m1_i` with type ≠ 00 is ignored; no refresh occurs.
- After any cycle, `a_o` holds the last driven value in IDLE.

## Timing
- **Reset values:**
  - All strobe outputs (`*_n_o`) = 1.
  - `a_o` = `RESET_ADDR`.
  - `d_o` = 0, `d_oe_o` = 0.
  - `rsp_valid_o` = 0, `rsp_data_o` = 0.
  - r_cnt = 0, state = IDLE.
- **Cycle length in ticks**, excluding IDLE, with n wait ticks:
  - Mem read or write: 3+n.
  - I/O: 4+n.
  - M1: 4+n.
- At least one IDLE tick separates consecutive cycles.
- `rsp_valid_o` asserts on the clock after the capture edge, for exactly one `clk_i` period, independent of `clk_en_i`.
- Strobes change only on tick edges.
- Reset mid-cycle: all strobes go high asynchronously, no `rsp_valid_o` pulse, the request is discarded, and r_cnt is cleared.
- `wait_n_i` is ignored outside the sampling points.
- `req_valid_i` is ignored while the FSM is not in IDLE.

## Test plan
- **Mem read, no wait:** `clk_en_i`=1, req 00 addr 16'h8000, `d_i`=8'hA5.
  - Required: `mreq_n_o`/`rd_n_o` low for 3 ticks, `rsp_data_o`=8'hA5 with a one-clock `rsp_valid_o` pulse, `req_ready_o` back to 1 on the 4th tick.
- **I/O write:** req 11 addr 16'h00BE data 8'h3C.
  - Required: `iorq_n_o`/`wr_n_o` low in T2, TWA and T3, `d_o`=8'h3C with `d_oe_o`=1 throughout, 4 ticks total.
- **Wait insertion:** mem write with `wait_n_i`=0 for 3 ticks.
  - Required: 6-tick cycle, `wr_n_o` low for 5 ticks, no early exit.
- **M1 fetch:** two M1 reads, first of opcode 8'h3E.
  - Required: data captured before refresh, refresh address 16'h0000 then 16'h0001 with `rfsh_n_o` low for 2 ticks each.
  - After 128 fetches, the refresh address wraps to 16'h0000.
- **Throttled and back-to-back:** `clk_en_i` high every 3rd clock, `req_valid_i` held high with two queued requests.
  - Required: state advances only on ticks, one IDLE tick between cycles, second request accepted only from IDLE.
- **Reset mid-cycle:** assert `reset_n_i` during T2 of an I/O read.
  - Required: all strobes high immediately, `d_oe_o`=0, no `rsp_valid_o` pulse, `a_o`=`RESET_ADDR`.

Source files
------------

// File: rtl/cv_bus_master.sv
// Z80-style bus initiator: turns single requests into T-state accurate
// memory, I/O and M1-with-refresh bus cycles.
module cv_bus_master #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clk_en_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_type_i,
    input  logic        req_m1_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [15:0] a_o,
    output logic [7:0]  d_o,
    output logic        d_oe_o,
    input  logic [7:0]  d_i,
    output logic        mreq_n_o,
    output logic        iorq_n_o,
    output logic        rd_n_o,
    output logic        wr_n_o,
    output logic        rfsh_n_o,
    output logic        m1_n_o,
    input  logic        wait_n_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4
    } state_t;

    state_t      r_state;
    logic        r_io;
    logic        r_wr;
    logic        r_m1;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_cnt;
    logic [15:0] r_a;
    logic [7:0]  r_d;
    logic        r_doe;
    logic        r_mreq_n;
    logic        r_iorq_n;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_rfsh_n;
    logic        r_m1_n;
    logic        r_rdy;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_data;

    state_t      w_nxt;
    logic        w_io;
    logic        w_wr;
    logic        w_m1;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic        w_cap;
    logic        w_inc;
    logic [15:0] w_a;
    logic [7:0]  w_d;
    logic        w_doe;
    logic        w_mreq_n;
    logic        w_iorq_n;
    logic        w_rd_n;
    logic        w_wr_n;
    logic        w_rfsh_n;
    logic        w_m1_n;

    // In IDLE the request inputs drive the T1 outputs directly
    always_comb begin
        w_io   = r_io;
        w_wr   = r_wr;
        w_m1   = r_m1;
        w_addr = r_addr;
        w_data = r_data;
        if (r_state == S_IDLE) begin
            w_io   = req_type_i[1];
            w_wr   = req_type_i[0];
            w_m1   = req_m1_i & (req_type_i == 2'b00);
            w_addr = req_addr_i;
            w_data = req_data_i;
        end
    end

    always_comb begin
        w_nxt = r_state;
        w_cap = 1'b0;
        w_inc = 1'b0;
        unique case (r_state)
            S_IDLE: if (req_valid_i) w_nxt = S_T1;
            S_T1:   w_nxt = S_T2;
            S_T2: begin
                if (r_io) begin
                    w_nxt = S_TWA;
                end else if (!wait_n_i) begin
                    w_nxt = S_TW;
                end else begin
                    w_nxt = S_T3;
                    w_cap = r_m1;
                end
            end
            S_TWA:  w_nxt = wait_n_i ? S_T3 : S_TW;
            S_TW: begin
                if (wait_n_i) begin
                    w_nxt = S_T3;
                    w_cap = r_m1;
                end
            end
            S_T3: begin
                w_nxt = r_m1 ? S_T4 : S_IDLE;
                w_cap = ~r_m1 & ~r_wr;
            end
            S_T4: begin
                w_nxt = S_IDLE;
                w_inc = 1'b1;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a      = r_a;
        w_d      = r_d;
        w_doe    = 1'b0;
        w_mreq_n = 1'b1;
        w_iorq_n = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_rfsh_n = 1'b1;
        w_m1_n   = 1'b1;
        unique case (w_nxt)
            S_T1: begin
                w_a = w_addr;
                if (!w_io) begin
                    w_mreq_n = 1'b0;
                    w_rd_n   = w_wr;
                end
                w_m1_n = ~w_m1;
                if (w_wr) begin
                    w_d   = w_data;
                    w_doe = 1'b1;
                end
            end
            S_T2, S_TWA, S_TW: begin
                w_a   = w_addr;
                w_doe = w_wr;
                if (w_io) begin
                    w_iorq_n = 1'b0;
                end else begin
                    w_mreq_n = 1'b0;
                    w_m1_n   = ~w_m1;
                end
                w_rd_n = w_wr;
                w_wr_n = ~w_wr;
            end
            S_T3: begin
                if (w_m1) begin
                    w_a      = {8'h00, r_cnt};
                    w_rfsh_n = 1'b0;
                    w_mreq_n = 1'b0;
                end else begin
                    w_a   = w_addr;
                    w_doe = w_wr;
                    if (w_io) w_iorq_n = 1'b0;
                    else      w_mreq_n = 1'b0;
                    w_rd_n = w_wr;
                    w_wr_n = ~w_wr;
                end
            end
            S_T4:    w_rfsh_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_io        <= 1'b0;
            r_wr        <= 1'b0;
            r_m1        <= 1'b0;
            r_addr      <= 16'h0000;
            r_data      <= 8'h00;
            r_cnt       <= 8'h00;
            r_a         <= RESET_ADDR;
            r_d         <= 8'h00;
            r_doe       <= 1'b0;
            r_mreq_n    <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_rfsh_n    <= 1'b1;
            r_m1_n      <= 1'b1;
            r_rdy       <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            // Pulse lasts one clk regardless of tick spacing
            r_rsp_valid <= clk_en_i & w_cap;
            if (clk_en_i) begin
                r_state <= w_nxt;
                if (r_state == S_IDLE && req_valid_i) begin
                    r_io   <= w_io;
                    r_wr   <= w_wr;
                    r_m1   <= w_m1;
                    r_addr <= w_addr;
                    r_data <= w_data;
                end
                if (w_cap) r_rsp_data <= d_i;
                if (w_inc) r_cnt <= {1'b0, r_cnt[6:0] + 7'd1};
                r_a      <= w_a;
                r_d      <= w_d;
                r_doe    <= w_doe;
                r_mreq_n <= w_mreq_n;
                r_iorq_n <= w_iorq_n;
                r_rd_n   <= w_rd_n;
                r_wr_n   <= w_wr_n;
                r_rfsh_n <= w_rfsh_n;
                r_m1_n   <= w_m1_n;
                r_rdy    <= (w_nxt == S_IDLE);
                r_busy   <= (w_nxt != S_IDLE);
            end
        end
    end

    assign req_ready_o = r_rdy;
    assign busy_o      = r_busy;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign a_o         = r_a;
    assign d_o         = r_d;
    assign d_oe_o      = r_doe;
    assign mreq_n_o    = r_mreq_n;
    assign iorq_n_o    = r_iorq_n;
    assign rd_n_o      = r_rd_n;
    assign wr_n_o      = r_wr_n;
    assign rfsh_n_o    = r_rfsh_n;
    assign m1_n_o      = r_m1_n;

endmodule

// File: tb/tb_cv_bus_master.sv
// Randomized bench for cv_bus_master; expected bus activity per tick is
// derived from cycle type, wait count and refresh counter.
module tb_cv_bus_master;

    localparam logic [15:0] RST_A = 16'h5A5A;

    logic        clk;
    logic        reset_n_i;
    logic        clk_en_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_type_i;
    logic        req_m1_i;
    logic [15:0] req_addr_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [15:0] a_o;
    logic [7:0]  d_o;
    logic        d_oe_o;
    logic [7:0]  d_i;
    logic        mreq_n_o;
    logic        iorq_n_o;
    logic        rd_n_o;
    logic        wr_n_o;
    logic        rfsh_n_o;
    logic        m1_n_o;
    logic        wait_n_i;
    logic        busy_o;

    cv_bus_master #(.RESET_ADDR(RST_A)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .clk_en_i   (clk_en_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_type_i (req_type_i),
        .req_m1_i   (req_m1_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .a_o        (a_o),
        .d_o        (d_o),
        .d_oe_o     (d_oe_o),
        .d_i        (d_i),
        .mreq_n_o   (mreq_n_o),
        .iorq_n_o   (iorq_n_o),
        .rd_n_o     (rd_n_o),
        .wr_n_o     (wr_n_o),
        .rfsh_n_o   (rfsh_n_o),
        .m1_n_o     (m1_n_o),
        .wait_n_i   (wait_n_i),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_pulse = 0;

    always @(negedge clk) if (rsp_valid_o === 1'b1) n_pulse++;

    int          cnt_m;
    logic [15:0] last_a;
    logic [7:0]  last_rsp;
    int          gap_lo;
    int          gap_hi;
    int          force_d;
    logic        keep_valid;
    logic [1:0]  nx_type;
    logic        nx_m1;
    logic [15:0] nx_addr;
    logic [7:0]  nx_data;
    logic [24:0] exp_bus;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [24:0] bus_now();
        return {req_ready_o, busy_o, a_o, mreq_n_o, iorq_n_o,
                rd_n_o, wr_n_o, rfsh_n_o, m1_n_o, d_oe_o};
    endfunction

    function automatic logic [24:0] idle_bus();
        return {1'b1, 1'b0, last_a, 6'b111111, 1'b0};
    endfunction

    task automatic step_tick();
        int g;
        g = int'($urandom_range(gap_hi, gap_lo));
        for (int i = 0; i < g; i++) begin
            clk_en_i = 1'b0;
            @(posedge clk);
            #1;
            check("hold", bus_now(), exp_bus);
        end
        clk_en_i = 1'b1;
        @(posedge clk);
        #1;
        clk_en_i = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] ty, input logic m1,
                           input logic [15:0] ad, input logic [7:0] dt,
                           input int nw);
        logic        io, wr, m1e;
        int          len, sp, cap, pul0;
        logic [7:0]  dcap;
        logic [15:0] a;
        logic        mq, ion, rd, wrn, rf, m1n, doe;
        io   = ty[1];
        wr   = ty[0];
        m1e  = m1 && (ty == 2'b00);
        len  = (io || m1e) ? 4 + nw : 3 + nw;
        sp   = io ? 2 : 1;
        cap  = wr ? -1 : (m1e ? sp + nw : len - 1);
        pul0 = n_pulse;
        dcap = 8'h00;
        req_valid_i = 1'b1;
        req_type_i  = ty;
        req_m1_i    = m1;
        req_addr_i  = ad;
        req_data_i  = dt;
        exp_bus = idle_bus();
        step_tick();
        for (int p = 0; p < len; p++) begin
            a = ad; mq = 1; ion = 1; rd = 1; wrn = 1; rf = 1; m1n = 1;
            doe = wr;
            if (m1e && p >= len - 2) begin
                a  = {8'h00, 8'(cnt_m)};
                rf = 0;
                mq = (p == len - 1);
            end else if (!io) begin
                mq = 0;
                if (!wr) rd = 0;
                else if (p >= 1) wrn = 0;
                m1n = !m1e;
            end else if (p >= 1) begin
                ion = 0;
                if (wr) wrn = 0;
                else rd = 0;
            end
            exp_bus = {1'b0, 1'b1, a, mq, ion, rd, wrn, rf, m1n, doe};
            check("bus", bus_now(), exp_bus);
            if (wr) check("dout", d_o, dt);
            if (keep_valid) begin
                req_valid_i = 1'b1;
                req_type_i  = nx_type;
                req_m1_i    = nx_m1;
                req_addr_i  = nx_addr;
                req_data_i  = nx_data;
            end else begin
                req_valid_i = 1'($urandom);
                req_type_i  = 2'($urandom);
                req_m1_i    = 1'($urandom);
                req_addr_i  = 16'($urandom);
                req_data_i  = 8'($urandom);
            end
            if (p >= sp && p < sp + nw) wait_n_i = 1'b0;
            else if (p == sp + nw) wait_n_i = 1'b1;
            else wait_n_i = 1'($urandom);
            d_i = 8'($urandom);
            if (p == cap) begin
                if (force_d >= 0) d_i = 8'(force_d);
                dcap = d_i;
            end
            step_tick();
            if (p == cap) begin
                check("rsp_valid", rsp_valid_o, 1);
                check("rsp_data", rsp_data_o, dcap);
                last_rsp = dcap;
            end
            last_a = a;
        end
        if (m1e) cnt_m = (cnt_m + 1) % 128;
        if (!keep_valid) req_valid_i = 1'b0;
        wait_n_i = 1'($urandom);
        exp_bus = idle_bus();
        check("idle", bus_now(), exp_bus);
        clk_en_i = 1'b0;
        @(posedge clk);
        #1;
        check("pulses", n_pulse - pul0, wr ? 0 : 1);
        check("rsp_hold", rsp_data_o, last_rsp);
        force_d = -1;
    endtask

    task automatic do_reset();
        #2 reset_n_i = 1'b0;
        #1;
        cnt_m    = 0;
        last_a   = RST_A;
        last_rsp = 8'h00;
        check("rst_bus", bus_now(), idle_bus());
        check("rst_dout", d_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_data_o}, 0);
        @(posedge clk);
        #3 reset_n_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        clk_en_i    = 1'b0;
        req_valid_i = 1'b0;
        req_type_i  = 2'b00;
        req_m1_i    = 1'b0;
        req_addr_i  = 16'h0000;
        req_data_i  = 8'h00;
        d_i         = 8'h00;
        wait_n_i    = 1'b1;
        gap_lo      = 0;
        gap_hi      = 0;
        force_d     = -1;
        keep_valid  = 1'b0;
        nx_type     = 2'b00;
        nx_m1       = 1'b0;
        nx_addr     = 16'h0000;
        nx_data     = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        force_d = 8'hA5;
        run_txn(2'b00, 1'b0, 16'h8000, 8'h00, 0);
        run_txn(2'b11, 1'b0, 16'h00BE, 8'h3C, 0);
        run_txn(2'b01, 1'b0, 16'h1234, 8'h77, 3);
        force_d = 8'h3E;
        run_txn(2'b00, 1'b1, 16'h0100, 8'h00, 0);
        run_txn(2'b00, 1'b1, 16'h0101, 8'h00, 1);
        run_txn(2'b10, 1'b1, 16'h0042, 8'h00, 2);
        run_txn(2'b11, 1'b1, 16'h0043, 8'h99, 0);

        gap_lo     = 2;
        gap_hi     = 2;
        keep_valid = 1'b1;
        nx_type    = 2'b10;
        nx_m1      = 1'b0;
        nx_addr    = 16'h00FE;
        nx_data    = 8'h00;
        run_txn(2'b01, 1'b0, 16'hC000, 8'h5E, 1);
        keep_valid = 1'b0;
        run_txn(nx_type, nx_m1, nx_addr, nx_data, 0);

        gap_lo = 0;
        gap_hi = 1;
        req_valid_i = 1'b1;
        req_type_i  = 2'b10;
        req_m1_i    = 1'b0;
        req_addr_i  = 16'h1234;
        wait_n_i    = 1'b1;
        exp_bus = idle_bus();
        step_tick();
        req_valid_i = 1'b0;
        step_tick();
        check("pre_rst", {iorq_n_o, rd_n_o, mreq_n_o}, 3'b001);
        n_pulse = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_bus = idle_bus();
            step_tick();
        end
        check("rst_idle", bus_now(), idle_bus());
        check("rst_nopulse", n_pulse, 0);
        check("rst_data", rsp_data_o, 0);

        gap_hi = 0;
        for (int i = 0; i < 130; i++)
            run_txn(2'b00, 1'b1, 16'($urandom), 8'h00, 0);

        gap_hi = 3;
        for (int i = 0; i < 150; i++)
            run_txn(2'($urandom), 1'($urandom), 16'($urandom),
                    8'($urandom), int'($urandom_range(3, 0)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
